// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared stall encodings, masks and multi-cycle EX sequencer states
package pipe_stall_ctrl_pkg;
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;
endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// stall_perf_cnt: saturating count of clock edges on which the PC is stalled
module stall_perf_cnt
    import pipe_stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] cnt
);
    always_ff @(posedge clk)
        if (rst)
            cnt <= '0;
        else if (en == STOP && cnt != 32'hFFFF_FFFF)
            cnt <= cnt + 32'd1;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall merge (EX > ID > IF) and multi-cycle EX start/done/timeout sequencer.
// Optional STALL_PERF_EN builds the stall_cycles performance counter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        ex_mc_req,
    input  logic        mc_done,
    output logic        mc_start,
    output logic        mc_result_sel,
    output logic        mc_timeout,
    output logic [5:0]  stall,
    output logic [31:0] stall_cycles
);
    localparam logic [7:0] CNT_LAST = 8'(MC_TIMEOUT - 1);

    mc_state_e  state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       ex_hold;

    always_ff @(posedge clk)
        if (rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        mc_start      = 1'b0;
        mc_result_sel = 1'b0;
        mc_timeout    = 1'b0;
        case (state)
            MC_IDLE:
                if (ex_mc_req) begin
                    mc_start = 1'b1;
                    cnt_nx   = '0;
                    state_nx = MC_BUSY;
                end
            MC_BUSY:
                if (mc_done)
                    state_nx = MC_DONE;
                else if (cnt == CNT_LAST) begin
                    mc_timeout = 1'b1;
                    state_nx   = MC_DONE;
                end else
                    cnt_nx = cnt + 8'd1;
            MC_DONE: begin
                mc_result_sel = 1'b1;
                state_nx      = MC_IDLE;
            end
            default: state_nx = MC_IDLE;
        endcase
        if (rst) begin
            mc_start      = 1'b0;
            mc_result_sel = 1'b0;
            mc_timeout    = 1'b0;
        end
    end

    // DONE drops the EX hold so the result commits while ID/IF requests still apply
    assign ex_hold = state == MC_BUSY || (state == MC_IDLE && ex_mc_req);
    assign stall   = rst         ? STALL_NONE :
                     ex_hold     ? STALL_EX   :
                     stallreq_id ? STALL_ID   :
                     stallreq_if ? STALL_IF   : STALL_NONE;

`ifdef STALL_PERF_EN
    stall_perf_cnt u_perf (
        .clk (clk),
        .rst (rst),
        .en  (stall[0]),
        .cnt (stall_cycles)
    );
`else
    assign stall_cycles = 32'h0;
`endif
endmodule
